// File: rtl/riscv_ram_pkg.sv
// Shared encodings for the RAM responder: access sizes and FSM states.
package riscv_ram_pkg;

    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HWORD = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/riscv_ram_1rw.sv
// Synchronous single-port RAM with per-byte write enables and a registered read.
// Contents are never reset.
module riscv_ram_1rw #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [XLEN-1:0]   rdata_o
);

    logic [XLEN-1:0] mem [DEPTH];

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < XLEN/8; i++) begin
            if (be_i[i]) begin
                mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/riscv_ram_responder.sv
// Memory-side responder: terminates physical requests into a local RAM with
// a programmable number of wait states. One outstanding request at a time.
//
// state | meaning
// IDLE  | waiting for preq_i; request attributes latched on acceptance
// WAIT  | burning wait states, counter counts down to 1
// ACK   | pack_o pulse, read data / error presented
module riscv_ram_responder
    import riscv_ram_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int PLEN        = 64,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            preq_i,
    input  logic [PLEN-1:0] padr_i,
    input  logic [2:0]      psize_i,
    input  logic            plock_i,
    input  logic [2:0]      pprot_i,
    input  logic            pwe_i,
    input  logic [XLEN-1:0] pd_i,
    output logic [XLEN-1:0] pq_o,
    output logic            pack_o,
    output logic            perr_o
);

    localparam int NB   = XLEN/8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            accept;
    logic [PLEN-1:0] adr_q;
    logic [2:0]      size_q;
    logic            we_q;
    logic [XLEN-1:0] wd_q;

    // Lock and protection attributes are accepted but have no effect here.
    logic unused_attr;
    assign unused_attr = ^{plock_i, pprot_i};

    // In IDLE the live request drives decode so a zero-wait access can hit
    // the RAM on its accept edge; afterwards the latched copy is used.
    logic            in_idle;
    logic [PLEN-1:0] cur_adr;
    logic [2:0]      cur_size;
    logic            cur_we;
    logic [XLEN-1:0] cur_wd;
    logic [OFFW-1:0] off;
    logic            size_err, align_err, range_err, err;
    logic [NB-1:0]   be, ram_be;
    logic            ram_we;
    logic [XLEN-1:0] ram_q;

    assign in_idle  = (state_q == IDLE);
    assign cur_adr  = in_idle ? padr_i  : adr_q;
    assign cur_size = in_idle ? psize_i : size_q;
    assign cur_we   = in_idle ? pwe_i   : we_q;
    assign cur_wd   = in_idle ? pd_i    : wd_q;
    assign off      = cur_adr[OFFW-1:0];

    assign size_err  = (cur_size > 3'(OFFW));
    assign range_err = |cur_adr[PLEN-1:OFFW+IDXW];
    assign err       = size_err | align_err | range_err;

    // Alignment check and byte-lane mask for the current access.
    always_comb begin
        align_err = 1'b0;
        for (int i = 0; i < OFFW; i++) begin
            if (off[i] && (i < int'(cur_size))) align_err = 1'b1;
        end
        be = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(off)) && (i < int'(off) + (1 << cur_size));
        end
    end

    // Next-state logic and wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (preq_i) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM is written only on the edge that enters ACK, so a reset during WAIT drops the write.
    assign ram_we = (state_d == ACK) && (state_q != ACK) && cur_we && !err;
    assign ram_be = be & {NB{ram_we}};

    // State, counter and request latch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                adr_q  <= padr_i;
                size_q <= psize_i;
                we_q   <= pwe_i;
                wd_q   <= pd_i;
            end
        end
    end

    riscv_ram_1rw #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .AW    (IDXW)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (cur_adr[OFFW+IDXW-1:OFFW]),
        .be_i    (ram_be),
        .wdata_i (cur_wd),
        .rdata_o (ram_q)
    );

    assign pack_o = (state_q == ACK);
    assign perr_o = pack_o && err;
    assign pq_o   = (pack_o && !we_q && !err) ? ram_q : '0;

endmodule

// File: tb/tb_riscv_ram_responder.sv
// Directed bench for riscv_ram_responder: vector table on a 2-wait-state
// instance plus throughput and reset sequences, the throughput one on a 0-wait-state instance.
module tb_riscv_ram_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        preq0 = 1'b0, preq1 = 1'b0;
    logic [63:0] padr = '0;
    logic [2:0]  psize = '0;
    logic        plock = 1'b0;
    logic [2:0]  pprot = '0;
    logic        pwe = 1'b0;
    logic [63:0] pd = '0;
    logic [63:0] pq0, pq1;
    logic        pack0, pack1, perr0, perr1;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    riscv_ram_responder #(.XLEN(64), .PLEN(64), .DEPTH(1024), .WAIT_STATES(2)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .preq_i(preq0), .padr_i(padr), .psize_i(psize),
        .plock_i(plock), .pprot_i(pprot), .pwe_i(pwe), .pd_i(pd),
        .pq_o(pq0), .pack_o(pack0), .perr_o(perr0)
    );

    riscv_ram_responder #(.XLEN(64), .PLEN(64), .DEPTH(1024), .WAIT_STATES(0)) dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .preq_i(preq1), .padr_i(padr), .psize_i(psize),
        .plock_i(plock), .pprot_i(pprot), .pwe_i(pwe), .pd_i(pd),
        .pq_o(pq1), .pack_o(pack1), .perr_o(perr1)
    );

    typedef struct {
        logic        we;
        logic [63:0] adr;
        logic [2:0]  size;
        logic [63:0] wd;
        logic        err;
        logic [63:0] q;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One access on dut0: drive at negedge, wait for pack, check latency and outputs.
    task automatic access0(input string name, input logic we, input logic [63:0] adr,
                           input logic [2:0] size, input logic [63:0] wd,
                           input logic exp_err, input logic [63:0] exp_q);
        int n;
        logic idle_bad;
        @(negedge clk_i);
        pwe = we; padr = adr; psize = size; pd = wd; preq0 = 1'b1;
        @(posedge clk_i);
        n = 0;
        idle_bad = 1'b0;
        while (n < 20) begin
            @(negedge clk_i);
            n++;
            if (pack0) break;
            if (pq0 !== 64'h0 || perr0 !== 1'b0) idle_bad = 1'b1;
        end
        check({name, "_pack_seen"}, 64'(pack0), 64'h1);
        check({name, "_latency"}, 64'(n), 64'd3);
        check({name, "_quiet_before_pack"}, 64'(idle_bad), 64'h0);
        check({name, "_perr"}, 64'(perr0), 64'(exp_err));
        check({name, "_pq"}, pq0, exp_q);
        preq0 = 1'b0;
        @(negedge clk_i);
        check({name, "_pack_one_cycle"}, 64'(pack0), 64'h0);
    endtask

    initial begin
        int pulses;
        logic pattern_bad;

        vecs[0]  = '{1'b1, 64'h100,  3'd3, 64'h1122334455667788, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 64'h100,  3'd3, 64'h0,                1'b0, 64'h1122334455667788};
        vecs[2]  = '{1'b1, 64'h103,  3'd0, 64'hFFFFFFFFABFFFFFF, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 64'h100,  3'd3, 64'h0,                1'b0, 64'h11223344AB667788};
        vecs[4]  = '{1'b1, 64'h101,  3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0};
        vecs[5]  = '{1'b0, 64'h100,  3'd3, 64'h0,                1'b0, 64'h11223344AB667788};
        vecs[6]  = '{1'b0, 64'h2000, 3'd3, 64'h0,                1'b1, 64'h0};
        vecs[7]  = '{1'b1, 64'h200,  3'd3, 64'h0,                1'b0, 64'h0};
        vecs[8]  = '{1'b1, 64'h204,  3'd2, 64'hDEADBEEF12345678, 1'b0, 64'h0};
        vecs[9]  = '{1'b1, 64'h202,  3'd1, 64'h99999999CAFE9999, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 64'h200,  3'd3, 64'h0,                1'b0, 64'hDEADBEEFCAFE0000};
        vecs[11] = '{1'b0, 64'h200,  3'd4, 64'h0,                1'b1, 64'h0};
        vecs[12] = '{1'b0, 64'h104,  3'd3, 64'h0,                1'b1, 64'h0};
        vecs[13] = '{1'b0, 64'h8000000000000100, 3'd3, 64'h0,    1'b1, 64'h0};
        vecs[14] = '{1'b1, 64'h1FF8, 3'd3, 64'hA5A5A5A55A5A5A5A, 1'b0, 64'h0};
        vecs[15] = '{1'b0, 64'h1FFC, 3'd2, 64'h0,                1'b0, 64'hA5A5A5A55A5A5A5A};
        vecs[16] = '{1'b0, 64'h1FFF, 3'd0, 64'h0,                1'b0, 64'hA5A5A5A55A5A5A5A};

        // Reset values
        repeat (2) @(negedge clk_i);
        check("reset_pack", 64'(pack0), 64'h0);
        check("reset_perr", 64'(perr0), 64'h0);
        check("reset_pq", pq0, 64'h0);
        check("reset_pack_ws0", 64'(pack1), 64'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Vector table on the 2-wait-state instance
        for (int i = 0; i < 17; i++) begin
            access0($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].size,
                    vecs[i].wd, vecs[i].err, vecs[i].q);
        end

        // Back-to-back on the 0-wait-state instance: preq held 10 edges
        @(negedge clk_i);
        pwe = 1'b0; padr = 64'h0; psize = 3'd3; pd = 64'h0; preq1 = 1'b1;
        pulses = 0;
        pattern_bad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            if (pack1) pulses++;
            if (pack1 !== ((k % 2) == 1)) pattern_bad = 1'b1;
            if (pack1 && perr1 !== 1'b0) pattern_bad = 1'b1;
        end
        preq1 = 1'b0;
        check("ws0_pulse_count", 64'(pulses), 64'd5);
        check("ws0_pulse_pattern", 64'(pattern_bad), 64'h0);

        // Reset during WAIT of a write drops it
        access0("rst_setup", 1'b1, 64'h300, 3'd3, 64'h0123456789ABCDEF, 1'b0, 64'h0);
        @(negedge clk_i);
        pwe = 1'b1; padr = 64'h300; psize = 3'd3; pd = 64'hFFFFFFFFFFFFFFFF; preq0 = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        preq0 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (pack0) pulses++;
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            if (pack0) pulses++;
        end
        check("rst_no_pack", 64'(pulses), 64'd0);
        access0("rst_readback", 1'b0, 64'h300, 3'd3, 64'h0, 1'b0, 64'h0123456789ABCDEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
